// File: rtl/logic_target_fifo.sv
// Implementation-target selector plus the standard elastic stream FIFO.
// Storage is a RAM of CAPACITY-1 words, a registered read stage and an output register.
`timescale 1ns/1ps

package logic_pkg;
    typedef enum logic [1:0] {
        TARGET_GENERIC        = 2'd0,
        TARGET_INTEL          = 2'd1,
        TARGET_INTEL_ARRIA_10 = 2'd2
    } target_t;
endpackage

module logic_target_fifo #(
    parameter logic_pkg::target_t TARGET       = logic_pkg::TARGET_GENERIC,
    parameter int                 WIDTH        = 8,
    parameter int                 CAPACITY     = 16,
    parameter int                 ALMOST_FULL  = CAPACITY - 1,
    parameter int                 ALMOST_EMPTY = 1,
    parameter int                 COUNT_WIDTH  = $clog2(CAPACITY + 1)
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic                   rx_tvalid,
    output logic                   rx_tready,
    input  logic [WIDTH-1:0]       rx_tdata,
    output logic                   tx_tvalid,
    input  logic                   tx_tready,
    output logic [WIDTH-1:0]       tx_tdata,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow
);

    localparam int DEPTH = CAPACITY - 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COUNT_WIDTH-1:0] CAP_C   = COUNT_WIDTH'(CAPACITY);
    localparam logic [PTR_W-1:0]       PTR_END = PTR_W'(DEPTH - 1);
    localparam logic [4:0]             STALL_LIMIT = 5'd16;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("logic_target_fifo: WIDTH must be >= 1");
        end
        if (CAPACITY < 2) begin : g_bad_capacity
            $error("logic_target_fifo: CAPACITY must be >= 2");
        end
        if (COUNT_WIDTH != $clog2(CAPACITY + 1)) begin : g_bad_count_width
            $error("logic_target_fifo: COUNT_WIDTH is derived and must not be overridden");
        end
    endgenerate

    logic                   push;
    logic                   pop;
    logic                   rd_en;
    logic                   out_load;
    logic                   stg_vld;
    logic [WIDTH-1:0]       stg_data;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [COUNT_WIDTH-1:0] unread;
    logic [COUNT_WIDTH-1:0] unread_nxt;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic [4:0]             stall_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_END) ? '0 : p + 1'b1;
    endfunction

    assign push     = rx_tvalid & rx_tready;
    assign pop      = tx_tvalid & tx_tready;
    assign out_load = stg_vld & (~tx_tvalid | tx_tready);
    // A RAM slot is released when its read is issued; the read stage holds the copy.
    assign rd_en    = (unread != '0) & (~stg_vld | out_load);

    assign unread_nxt = unread + COUNT_WIDTH'(push) - COUNT_WIDTH'(rd_en);
    assign count_nxt  = count + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);

    // Same-edge write and read of one slot must return the old word (full wrap case).
    generate
        if (TARGET == logic_pkg::TARGET_GENERIC) begin : g_ram_generic
            logic [WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge aclk) begin
                if (push)  mem[wr_ptr] <= rx_tdata;
                if (rd_en) stg_data    <= mem[rd_ptr];
            end
        end else if (TARGET == logic_pkg::TARGET_INTEL_ARRIA_10) begin : g_ram_a10
            (* ramstyle = "M20K" *) logic [WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge aclk) begin
                if (push)  mem[wr_ptr] <= rx_tdata;
                if (rd_en) stg_data    <= mem[rd_ptr];
            end
        end else if (TARGET == logic_pkg::TARGET_INTEL) begin : g_ram_intel
            (* ramstyle = "auto" *) logic [WIDTH-1:0] mem [DEPTH];
            always_ff @(posedge aclk) begin
                if (push)  mem[wr_ptr] <= rx_tdata;
                if (rd_en) stg_data    <= mem[rd_ptr];
            end
        end else begin : g_bad_target
            $error("logic_target_fifo: unsupported TARGET");
        end
    endgenerate

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            unread    <= '0;
            stg_vld   <= 1'b0;
            tx_tvalid <= 1'b0;
            tx_tdata  <= '0;
        end else begin
            if (push)  wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            unread    <= unread_nxt;
            stg_vld   <= rd_en | (stg_vld & ~out_load);
            tx_tvalid <= out_load | (tx_tvalid & ~tx_tready);
            if (out_load) tx_tdata <= stg_data;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            count        <= '0;
            rx_tready    <= 1'b0;
            almost_full  <= (ALMOST_FULL == 0);
            almost_empty <= 1'b1;
        end else begin
            count        <= count_nxt;
            rx_tready    <= (count_nxt < CAP_C);
            almost_full  <= (int'(count_nxt) >= ALMOST_FULL);
            almost_empty <= (int'(count_nxt) <= ALMOST_EMPTY);
        end
    end

    // Overflow flags a source that has been stalled against a full FIFO for 16+ cycles.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            stall_cnt <= '0;
            overflow  <= 1'b0;
        end else if (rx_tvalid && (count == CAP_C)) begin
            if (stall_cnt != STALL_LIMIT) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= STALL_LIMIT - 5'd1) overflow <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule
